// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory bus arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } state_t;

    function automatic logic [1:0] owner_of(input state_t s);
        case (s)
            ST_GNT_I: owner_of = OWN_I;
            ST_GNT_D: owner_of = OWN_D;
            default:  owner_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Stall counter for the granted master; pulses err for one cycle when the
// memory leaves a strobed access unacknowledged for TIMEOUT_CYC cycles.
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stb,
    input  logic akn,
    output logic err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= 1'b0;
            if (!active || akn) begin
                cnt <= '0;
            end else if (stb) begin
                // The stalled cycle that brings the count to TIMEOUT_CYC raises err.
                if (cnt == LAST) begin
                    cnt <= '0;
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch (I) and load/store (D).
// Optional access timeout is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cyc,
    input  logic            i_stb,
    input  logic [AW-1:0]   i_addr,
    output logic            i_akn,
    output logic            i_err,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_cyc,
    input  logic            d_stb,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_sel,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_akn,
    output logic            d_err,
    output logic [DW-1:0]   d_rdata,
    output logic            m_cyc,
    output logic            m_stb,
    output logic            m_we,
    output logic [DW/8-1:0] m_sel,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_akn,
    input  logic [DW-1:0]   m_rdata,
    output logic [1:0]      owner
);

    state_t     state;
    logic [1:0] last_owner;
    logic       tmo_err;

    // Grant FSM; owner is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            last_owner <= OWN_I;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cyc && (!d_cyc || last_owner == OWN_D)) begin
                        state <= ST_GNT_I;
                        owner <= owner_of(ST_GNT_I);
                    end else if (d_cyc) begin
                        state <= ST_GNT_D;
                        owner <= owner_of(ST_GNT_D);
                    end
                end
                ST_GNT_I: begin
                    if (!i_cyc) begin
                        state      <= ST_IDLE;
                        owner      <= OWN_NONE;
                        last_owner <= OWN_I;
                    end
                end
                ST_GNT_D: begin
                    if (!d_cyc) begin
                        state      <= ST_IDLE;
                        owner      <= OWN_NONE;
                        last_owner <= OWN_D;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

    // Forward path follows the registered owner; everything is zero when idle.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_sel   = '0;
        m_addr  = '0;
        m_wdata = '0;
        case (owner)
            OWN_I: begin
                m_cyc  = i_cyc;
                m_stb  = i_stb;
                m_sel  = '1;
                m_addr = i_addr;
            end
            OWN_D: begin
                m_cyc   = d_cyc;
                m_stb   = d_stb;
                m_we    = d_we;
                m_sel   = d_sel;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .active (state != ST_IDLE),
        .stb    (m_stb),
        .akn    (m_akn),
        .err    (tmo_err)
    );
`else
    // Keeps TIMEOUT_CYC referenced when the timeout logic is compiled out.
    assign tmo_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    // Read data is broadcast; only the owner's akn qualifies it.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign i_akn   = (owner == OWN_I) && m_akn && !tmo_err;
    assign d_akn   = (owner == OWN_D) && m_akn && !tmo_err;
    assign i_err   = (owner == OWN_I) && tmo_err;
    assign d_err   = (owner == OWN_D) && tmo_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the grant rules.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          i_cyc, i_stb, i_akn, i_err;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_cyc, d_stb, d_we, d_akn, d_err;
    logic [SW-1:0] d_sel;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_cyc, m_stb, m_we, m_akn;
    logic [SW-1:0] m_sel;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [1:0]    owner;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_addr(i_addr), .i_akn(i_akn),
        .i_err(i_err), .i_rdata(i_rdata),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_akn(d_akn), .d_err(d_err),
        .d_rdata(d_rdata),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_akn(m_akn), .m_rdata(m_rdata),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: granted master (0 none, 1 I, 2 D), last released master,
    // stall count of the current access and the pending error pulse.
    int mdl_own  = 0;
    int mdl_last = 1;
    int mdl_cnt  = 0;
    bit mdl_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mdl_own  = 0;
        mdl_last = 1;
        mdl_cnt  = 0;
        mdl_err  = 1'b0;
    endtask

    task automatic compare_outputs();
        bit gi, gd;
        gi = (mdl_own == 1);
        gd = (mdl_own == 2);
        check("owner",   owner,   64'(mdl_own));
        check("m_cyc",   m_cyc,   gi ? i_cyc : gd ? d_cyc : 1'b0);
        check("m_stb",   m_stb,   gi ? i_stb : gd ? d_stb : 1'b0);
        check("m_we",    m_we,    gd ? d_we : 1'b0);
        check("m_sel",   m_sel,   gi ? {SW{1'b1}} : gd ? d_sel : '0);
        check("m_addr",  m_addr,  gi ? i_addr : gd ? d_addr : '0);
        check("m_wdata", m_wdata, gd ? d_wdata : '0);
        check("i_akn",   i_akn,   gi && m_akn && !mdl_err);
        check("d_akn",   d_akn,   gd && m_akn && !mdl_err);
        check("i_err",   i_err,   gi && mdl_err);
        check("d_err",   d_err,   gd && mdl_err);
        check("i_rdata", i_rdata, m_rdata);
        check("d_rdata", d_rdata, m_rdata);
    endtask

    // Applies the arbitration rules to the inputs seen at the clock edge.
    task automatic model_update();
        int nxt;
        bit stb;
        nxt = mdl_own;
        if (mdl_own == 0) begin
            mdl_cnt = 0;
            mdl_err = 1'b0;
        end else begin
            stb = (mdl_own == 1) ? i_stb : d_stb;
            mdl_err = 1'b0;
            if (m_akn) begin
                mdl_cnt = 0;
            end else if (TMO_EN && stb) begin
                mdl_cnt++;
                if (mdl_cnt == TO) begin
                    mdl_err = 1'b1;
                    mdl_cnt = 0;
                end
            end
        end
        if (mdl_own == 0) begin
            if (i_cyc && d_cyc) nxt = (mdl_last == 1) ? 2 : 1;
            else if (i_cyc)     nxt = 1;
            else if (d_cyc)     nxt = 2;
        end else if (mdl_own == 1 && !i_cyc) begin
            nxt = 0;
            mdl_last = 1;
        end else if (mdl_own == 2 && !d_cyc) begin
            nxt = 0;
            mdl_last = 2;
        end
        mdl_own = nxt;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        compare_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_cyc = 0; i_stb = 0; i_addr = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0; d_addr = '0; d_wdata = '0;
        m_akn = 0; m_rdata = '0;
    endtask

    task automatic randomize_inputs(input int akn_pct);
        i_cyc   = i_cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        d_cyc   = d_cyc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
        i_stb   = ($urandom_range(0, 3) != 0);
        d_stb   = ($urandom_range(0, 3) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_sel   = SW'($urandom_range(0, (1 << SW) - 1));
        i_addr  = $urandom;
        d_addr  = $urandom;
        d_wdata = $urandom;
        m_akn   = ($urandom_range(0, 99) < akn_pct);
        m_rdata = $urandom;
    endtask

    int pulses;
    int akns;

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        compare_outputs();
        check("reset_owner", owner, 2'b00);
        rst = 1'b1;
        @(negedge clk);

        // Single I read
        i_cyc = 1; i_stb = 1; i_addr = 32'h100;
        cycle();
        m_akn = 1; m_rdata = 32'hDEADBEEF;
        #1;
        check("rd_m_cyc", m_cyc, 1'b1);
        check("rd_m_addr", m_addr, 32'h100);
        check("rd_i_akn", i_akn, 1'b1);
        check("rd_i_rdata", i_rdata, 32'hDEADBEEF);
        check("rd_d_akn", d_akn, 1'b0);
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Contention: D first after reset, then I after one idle cycle
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        #1;
        check("cont1_owner", owner, 2'b10);
        m_akn = 1;
        cycle();
        m_akn = 0; d_cyc = 0; d_stb = 0;
        cycle();
        #1;
        check("gap_m_cyc", m_cyc, 1'b0);
        check("gap_owner", owner, 2'b00);
        cycle();
        #1;
        check("cont1_next_owner", owner, 2'b01);
        i_cyc = 0; i_stb = 0;
        cycle();
        cycle();
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        #1;
        check("cont2_owner", owner, 2'b10);
        idle_inputs();
        cycle();
        cycle();

        // D write forwarding
        d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234;
        cycle();
        m_akn = 1;
        #1;
        check("wr_m_we", m_we, 1'b1);
        check("wr_m_sel", m_sel, 4'b0011);
        check("wr_m_wdata", m_wdata, 32'h1234);
        check("wr_m_addr", m_addr, 32'h200);
        check("wr_i_akn", i_akn, 1'b0);
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // I burst of 4 beats while D waits
        i_cyc = 1; i_stb = 1;
        cycle();
        d_cyc = 1; d_stb = 1; m_akn = 1;
        akns = 0;
        for (int b = 0; b < 4; b++) begin
            i_addr = 32'h400 + 32'(b * 4);
            #1;
            akns += int'(i_akn);
            check("burst_owner", owner, 2'b01);
            cycle();
        end
        check("burst_akns", akns, 4);
        i_cyc = 0; i_stb = 0; m_akn = 0;
        cycle();
        cycle();
        #1;
        check("burst_then_d", owner, 2'b10);
        idle_inputs();
        cycle();
        cycle();

        // Asynchronous reset in the middle of a D grant
        d_cyc = 1; d_stb = 1;
        cycle();
        m_akn = 1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_m_cyc", m_cyc, 1'b0);
        check("arst_owner", owner, 2'b00);
        check("arst_d_akn", d_akn, 1'b0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        #1;
        check("arst_cont_owner", owner, 2'b10);
        idle_inputs();
        cycle();
        cycle();

        // Stalled I access: one error pulse after TO stalled cycles when enabled
        i_cyc = 1; i_stb = 1; i_addr = 32'h800;
        cycle();
        pulses = 0;
        for (int k = 0; k < TO + 4; k++) begin
            #1;
            pulses += int'(i_err);
            cycle();
        end
        check("tmo_pulses", pulses, TMO_EN ? 1 : 0);
        idle_inputs();
        cycle();
        cycle();

        // Randomized traffic: frequent acks, then long stalls
        for (int n = 0; n < 300; n++) begin
            randomize_inputs(60);
            cycle();
        end
        for (int n = 0; n < 300; n++) begin
            randomize_inputs(8);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single external memory bus between the fetch path (instruction master, I) and the load/store path (data master, D).
- Sits between the fetch controller / load-store unit and the memory slave.
- Grants whole bus cycles (cyc held) to one master at a time, routes address/data/strobe forward and akn/read data back.
- Round-robin on contention.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYC, 255, max wait cycles for akn before forced error (used only with the optional feature; counter width is clog2(TIMEOUT_CYC+1)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- i_cyc  in  1  instruction master cycle request.
- i_stb  in  1  instruction master strobe.
- i_addr  in  AW  instruction fetch address.
- i_akn  out  1  acknowledge to instruction master.
- i_err  out  1  timeout error to instruction master.
- i_rdata  out  DW  read data to instruction master.
- d_cyc  in  1  data master cycle request.
- d_stb  in  1  data master strobe.
- d_we  in  1  data master write enable.
- d_sel  in  DW/8  data master byte selects.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_akn  out  1  acknowledge to data master.
- d_err  out  1  timeout error to data master.
- d_rdata  out  DW  read data to data master.
- m_cyc  out  1  bus cycle to memory.
- m_stb  out  1  bus strobe to memory.
- m_we  out  1  bus write enable.
- m_sel  out  DW/8  bus byte selects.
- m_addr  out  AW  bus address.
- m_wdata  out  DW  bus write data.
- m_akn  in  1  memory acknowledge.
- m_rdata  in  DW  memory read data.
- owner  out  2  current grant: 00 none, 01 I, 10 D.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst low, any time incl. mid-transfer):
  - state=IDLE, owner=00, last_owner=I (so D wins first contention), timeout counter=0.
  - All m_* outputs 0; i_akn, d_akn, i_err, d_err all 0.
  - No request is replayed after reset.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only i_cyc -> GNT_I next cycle.
  - Only d_cyc -> GNT_D next cycle.
  - Both -> grant to the master not equal to last_owner.
  - Neither -> stay.
- Grant latency: 1 cycle from request cyc to m_cyc high; owner is registered.
- GNT_x:
  - m_cyc=x_cyc, m_stb=x_stb; m_addr/m_we/m_sel/m_wdata forwarded combinationally from x.
  - For I: m_we=0, m_sel=all ones, m_wdata=0.
- Return path:
  - x_akn = m_akn when owner=x, else 0.
  - i_rdata and d_rdata both driven from m_rdata; only the owner's akn qualifies it.
  - Non-owner akn is always 0.
- Release:
  - When x_cyc drops in GNT_x, state -> IDLE next cycle and last_owner <= x.
  - Mandatory one idle cycle (m_cyc=0) between owners, even if the other master is waiting.
- Burst: the owner keeps the grant for any number of akn'd beats while its cyc stays high; no preemption.
- Simultaneous events:
  - Release of x and request of y in the same cycle -> IDLE, then GNT_y.
  - m_akn arriving in IDLE is ignored.
- In IDLE all m_* outputs are 0.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle in GNT_x with m_stb=1 and m_akn=0; it clears on m_akn or on leaving GNT_x.
  - When the count reaches TIMEOUT_CYC: x_err pulses 1 for one cycle, x_akn stays 0, and the counter clears.
  - The master must then drop cyc; normal release follows.
- Not defined: no counter logic; i_err=d_err=0 constantly.

Decomposition:
- Shared package: owner encodings (OWN_NONE=2'b00, OWN_I=2'b01, OWN_D=2'b10) and state encodings.
- One natural sub-module: mem_arb_timeout, the counter plus err pulse generator, instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Reset, then i_cyc=i_stb=1, i_addr=0x100 -> m_cyc=1 and m_addr=0x100 one cycle later; m_akn=1 with m_rdata=0xDEADBEEF -> i_akn=1 and i_rdata=0xDEADBEEF; d_akn=0.
- i_cyc and d_cyc both asserted from IDLE right after reset -> owner=10 (D) first.
  - After d_cyc drops: one m_cyc=0 cycle, then owner=01.
  - Next contention -> D again.
- D write: d_we=1, d_sel=4'b0011, d_addr=0x200, d_wdata=0x1234 -> m_we=1, m_sel=0011, m_wdata=0x1234; i_akn stays 0 throughout.
- I burst of 4 beats with i_cyc held while d_cyc pending -> 4 i_akn pulses, no grant switch until i_cyc falls.
- rst low mid-GNT_D (m_akn pending) -> same cycle: m_cyc=0, owner=00, d_akn=0; after release, first contention goes to D.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, owner I, stb held and no m_akn -> i_err=1 for exactly one cycle after 8 stalled cycles, i_akn=0.
